fp_mixer: RTL and testbench
===========================

FP_MIXER -- requirements
Module: fp_mixer

Interface
REQ-001 Parameter NVOICES, default 8: number of float32 samples summed per output frame, legal range 2..256.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for the adder's done signal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  32  IEEE-754 single-precision voice sample.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  32  float32 sum of one frame.
REQ-009 out_valid  output  1  out_data is valid; held until accepted.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 add_start  output  1  drives the adder's active-high synchronous load/reset input.
REQ-012 add_a, add_b  output  32 each  adder operands.
REQ-013 add_result  input  32  adder sum.
REQ-014 add_done  input  1  adder completion flag, level-high until the next load.
REQ-015 err  output  1  sticky flag: adder timeout occurred.

Function
REQ-016 A transfer on either stream SHALL occur only on a cycle where valid and ready are both high.
REQ-017 The FSM SHALL have the states IDLE, START, WAIT and EMIT.
REQ-018 IDLE: in_ready=1; the first sample of a frame is copied into acc with no add, and the voice count becomes 1.
REQ-019 IDLE, count≥1: an accepted sample is latched into add_b, acc is driven on add_a, and the FSM goes to START.
REQ-020 START: add_start=1 for exactly one cycle with add_a/add_b stable; the next state is WAIT.
REQ-021 add_a and add_b SHALL stay stable from START through WAIT exit.
REQ-022 WAIT: in_ready=0.
REQ-023 WAIT, add_done=1: acc←add_result and count increments; if count reaches NVOICES the FSM goes to EMIT, otherwise to IDLE.
REQ-024 WAIT: add_done SHALL be ignored on the first WAIT cycle, because the adder clears it one cycle after its load.
REQ-025 WAIT: if add_done has not risen within TIMEOUT cycles, err is set, acc is kept unchanged, and processing proceeds as if the add had completed.
REQ-026 EMIT: out_valid=1, out_data=acc, in_ready=0.
REQ-027 EMIT, out_ready=1: the next state is IDLE and count becomes 0.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Throughput: one sample per add latency plus 2 cycles; a frame emits at the earliest one cycle after the final add completes.
REQ-030 The count register width SHALL be clog2(NVOICES+1); it never wraps within a frame.
REQ-031 A zero result (0x00000000) SHALL be accumulated like any other value; the block does no float arithmetic itself.
REQ-032 Holding out_ready high continuously SHALL cost no extra cycle: IDLE re-enters with in_ready=1 the cycle after the EMIT handshake.
REQ-033 Only in_valid/in_ready and out_valid/out_ready may be high in the same cycle, and only in different states, so no collision can occur.

Reset
REQ-034 Reset assertion SHALL asynchronously force state=IDLE, count=0, acc=0, add_a=add_b=0, add_start=0, out_valid=0, err=0.
REQ-035 Reset assertion mid-frame SHALL discard the partial sum; the first sample after release starts a new frame.
REQ-036 Reset assertion during START SHALL drop add_start immediately, with no partial pulse after release.
REQ-037 err SHALL clear only on reset.

Structure
REQ-038 A shared package SHALL hold the state encoding, the float32 width constant FP_W=32, and the constants FP_ZERO, FP_ONE=0x3F800000 and FP_TWO=0x40000000.
REQ-039 A single sub-module, fp_timeout_counter, SHALL be used: a load/enable down-counter with an expiry flag.
REQ-040 The adder SHALL be instantiated outside this block, alongside it in the DSP path.

Verification
REQ-041 NVOICES=2; inputs 0x3F800000 and 0x3F800000 with a real adder -> one out_valid, out_data=0x40000000, err=0.
REQ-042 NVOICES=3; inputs 1.0, 2.0, 0.5 (0x3F800000, 0x40000000, 0x3F000000) -> out_data=0x40600000 (3.5).
REQ-043 NVOICES=2; inputs 0x3F800000 and 0xBF800000 -> out_data=0x00000000.
REQ-044 out_ready held low for 10 cycles during EMIT -> out_data stable, in_ready=0 throughout, no samples lost; the next frame sums correctly.
REQ-045 Stubbed adder that never raises add_done -> err=1 exactly TIMEOUT+1 cycles after add_start, the frame still emits, and err stays 1 until reset.
REQ-046 Reset pulsed low in WAIT after 3 of 8 samples -> immediate IDLE with out_valid=0; the next 8 samples of 1.0 give out_data=0x41000000.

Source files
------------

// File: rtl/fp_mixer_pkg.sv
// Shared definitions for the float32 voice mixer: FSM encoding and float32 constants.
// The mixer does no float arithmetic; these constants name well-known operand patterns.
package fp_mixer_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO  = 32'h4000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StEmit  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_timeout_counter.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module fp_timeout_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [Width-1:0] load_val,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/fp_mixer.sv
// Accumulates NVOICES float32 samples per frame through an external adder and
// emits the frame sum; a stalled adder is bounded by a timeout that sets a sticky err.
module fp_mixer
  import fp_mixer_pkg::*;
#(
  parameter int unsigned NVOICES = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FP_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [FP_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            add_start,
  output logic [FP_W-1:0] add_a,
  output logic [FP_W-1:0] add_b,
  input  logic [FP_W-1:0] add_result,
  input  logic            add_done,
  output logic            err
);

  localparam int unsigned CntW = $clog2(NVOICES + 1);
  localparam int unsigned TimW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic [CntW-1:0] count_q, count_d;
  logic [FP_W-1:0] acc_q, acc_d;
  logic [FP_W-1:0] add_a_q, add_a_d;
  logic [FP_W-1:0] add_b_q, add_b_d;
  logic            err_q, err_d;
  logic            first_q, first_d;

  logic            tmo_expired;
  logic            done_ok;
  logic            timed_out;
  logic            wait_end;
  logic [CntW-1:0] count_inc;
  logic            last_voice;

  // add_done is stale on the first WAIT cycle: the adder clears it one cycle after load
  assign done_ok    = (state_q == StWait) && !first_q && add_done;
  assign timed_out  = (state_q == StWait) && tmo_expired && !done_ok;
  assign wait_end   = done_ok || timed_out;
  assign count_inc  = count_q + CntW'(1);
  assign last_voice = (count_inc == CntW'(NVOICES));

  fp_timeout_counter #(
    .Width (TimW)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StStart),
    .en       (state_q == StWait),
    .load_val (TimW'(TIMEOUT - 1)),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid && (count_q != '0)) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (wait_end) state_d = last_voice ? StEmit : StIdle;
      StEmit:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    add_start = (state_q == StStart);
    out_valid = (state_q == StEmit);
    out_data  = acc_q;
    add_a     = add_a_q;
    add_b     = add_b_q;
    err       = err_q;
  end

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    err_d   = err_q;
    first_d = first_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (count_q == '0) begin
            acc_d   = in_data;
            count_d = CntW'(1);
          end else begin
            add_a_d = acc_q;
            add_b_d = in_data;
          end
        end
      end
      StStart: first_d = 1'b1;
      StWait: begin
        first_d = 1'b0;
        if (done_ok) acc_d = add_result;
        if (wait_end) count_d = count_inc;
        if (timed_out) err_d = 1'b1;
      end
      StEmit: if (out_ready) count_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      acc_q   <= FP_ZERO;
      add_a_q <= FP_ZERO;
      add_b_q <= FP_ZERO;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_fp_mixer.sv
// Bench for fp_mixer: three instances (NVOICES 2, 3, 8) each paired with a behavioural
// float adder; a real-valued frame-sum model checks every output handshake.
module tb_fp_mixer;

  localparam int TO  = 16;
  localparam int LAT = 3;

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] NEG1 = 32'hBF80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] HALF = 32'h3F00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] out_data  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        add_start [3];
  logic [31:0] add_a     [3];
  logic [31:0] add_b     [3];
  logic        err       [3];
  bit          stub_never  [3];
  bit          err_allowed [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic real f32_to_real(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  // Exact for the short-mantissa values used here
  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0000_0000;
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic int nv_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned NV = (g == 0) ? 2 : (g == 1) ? 3 : 8;
    logic        pend;
    logic        done_q;
    logic [31:0] res_q;
    int          lat_q;

    fp_mixer #(
      .NVOICES (NV),
      .TIMEOUT (TO)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .add_start  (add_start[g]),
      .add_a      (add_a[g]),
      .add_b      (add_b[g]),
      .add_result (res_q),
      .add_done   (done_q),
      .err        (err[g])
    );

    // Adder: done stays high until one cycle after the next load, then rises LAT later
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        pend   <= 1'b0;
        done_q <= 1'b0;
        res_q  <= 32'h0;
        lat_q  <= 0;
      end else begin
        pend <= add_start[g];
        if (pend) begin
          done_q <= 1'b0;
          res_q  <= real_to_f32(f32_to_real(add_a[g]) + f32_to_real(add_b[g]));
          lat_q  <= LAT;
        end else if (lat_q > 0) begin
          lat_q <= lat_q - 1;
          if (lat_q == 1 && !stub_never[g]) done_q <= 1'b1;
        end
      end
    end
  end

  // Frame model: running real sum per instance, expected sums queued at frame end
  real         msum    [3];
  int          mcnt    [3];
  logic [31:0] exp_q   [3][$];
  bit          held    [3];
  logic [31:0] held_d  [3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!reset) begin
        msum[g] = 0.0;
        mcnt[g] = 0;
        exp_q[g].delete();
        held[g] = 1'b0;
      end else begin
        if (in_valid[g] && in_ready[g]) begin
          if (mcnt[g] == 0) msum[g] = f32_to_real(in_data[g]);
          else if (!stub_never[g]) msum[g] = msum[g] + f32_to_real(in_data[g]);
          mcnt[g]++;
          if (mcnt[g] == nv_of(g)) begin
            exp_q[g].push_back(real_to_f32(msum[g]));
            mcnt[g] = 0;
          end
        end
        if (out_valid[g]) begin
          check($sformatf("in_ready_low_in_emit[%0d]", g), 32'(in_ready[g]), 32'd0);
          if (held[g]) check($sformatf("out_data_hold[%0d]", g), out_data[g], held_d[g]);
          if (out_ready[g]) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("unexpected_frame[%0d]", g), 32'(out_valid[g]), 32'd0);
            end else begin
              check($sformatf("frame_sum[%0d]", g), out_data[g], exp_q[g].pop_front());
            end
          end
        end
        held[g]   = out_valid[g] && !out_ready[g];
        held_d[g] = out_data[g];
        if (!err_allowed[g]) check($sformatf("err_clear[%0d]", g), 32'(err[g]), 32'd0);
      end
    end
  end

  task automatic send(input int g, input logic [31:0] d);
    bit ok;
    ok          = 1'b0;
    in_data[g]  = d;
    in_valid[g] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[g]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid[g] = 1'b0;
    if (!ok) check($sformatf("send_accepted[%0d]", g), 32'd0, 32'd1);
  endtask

  task automatic expect_out(input int g, input logic [31:0] exp, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid[g] && out_ready[g]) begin
        check(name, out_data[g], exp);
        ok = 1'b1;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_data[g]     = 32'h0;
      in_valid[g]    = 1'b0;
      out_ready[g]   = 1'b1;
      stub_never[g]  = 1'b0;
      err_allowed[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_in_ready", 32'(in_ready[g]), 32'd1);
      check("rst_out_valid", 32'(out_valid[g]), 32'd0);
      check("rst_add_start", 32'(add_start[g]), 32'd0);
      check("rst_err", 32'(err[g]), 32'd0);
      check("rst_add_a", add_a[g], 32'h0);
      check("rst_add_b", add_b[g], 32'h0);
      check("rst_out_data", out_data[g], 32'h0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    send(0, ONE); send(0, ONE);
    expect_out(0, 32'h4000_0000, "sum_one_one");

    send(1, ONE); send(1, TWO); send(1, HALF);
    expect_out(1, 32'h4060_0000, "sum_three_half");

    send(0, ONE); send(0, NEG1);
    expect_out(0, 32'h0000_0000, "cancel_to_zero");

    send(1, ONE); send(1, NEG1); send(1, TWO);
    expect_out(1, TWO, "zero_partial_sum");

    // Backpressure: EMIT held 10 cycles with a sample pending upstream
    out_ready[1] = 1'b0;
    send(1, TWO); send(1, TWO); send(1, TWO);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        seen = out_valid[1];
      end
      check("bp_emit_reached", 32'(seen), 32'd1);
    end
    in_data[1]  = ONE;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid[1]), 32'd1);
      check("bp_out_data", out_data[1], 32'h40C0_0000);
      check("bp_in_ready", 32'(in_ready[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_emit", 32'(in_ready[1]), 32'd1);
    send(1, ONE); send(1, ONE); send(1, ONE);
    expect_out(1, 32'h4040_0000, "next_frame_after_bp");

    // Reset in WAIT after 3 of 8 samples
    send(2, ONE); send(2, ONE); send(2, ONE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_wait_in_ready", 32'(in_ready[2]), 32'd1);
    check("rst_wait_out_valid", 32'(out_valid[2]), 32'd0);
    check("rst_wait_out_data", out_data[2], 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) send(2, ONE);
    expect_out(2, 32'h4100_0000, "eight_ones");

    // Reset during START drops add_start at once and leaves no pulse
    send(1, TWO); send(1, ONE);
    check("start_pulse", 32'(add_start[1]), 32'd1);
    check("start_add_a", add_a[1], TWO);
    check("start_add_b", add_b[1], ONE);
    reset = 1'b0;
    #1;
    check("rst_start_drop", 32'(add_start[1]), 32'd0);
    check("rst_start_add_a", add_a[1], 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("no_pulse_after_rst", 32'(add_start[1]), 32'd0);
    end
    send(1, TWO); send(1, HALF); send(1, HALF);
    expect_out(1, 32'h4040_0000, "frame_after_start_rst");

    // Adder that never completes: err exactly TO+1 cycles after add_start
    stub_never[0]  = 1'b1;
    err_allowed[0] = 1'b1;
    send(0, 32'h4040_0000); send(0, ONE);
    check("tmo_start", 32'(add_start[0]), 32'd1);
    for (int k = 1; k <= TO + 1; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmo_err_k%0d", k), 32'(err[0]), (k == TO + 1) ? 32'd1 : 32'd0);
    end
    check("tmo_emit", 32'(out_valid[0]), 32'd1);
    check("tmo_acc_kept", out_data[0], 32'h4040_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("err_sticky", 32'(err[0]), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("err_cleared_by_rst", 32'(err[0]), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    stub_never[0]  = 1'b0;
    err_allowed[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int g = 0; g < 3; g++) begin
      check($sformatf("no_lost_frames[%0d]", g), 32'(exp_q[g].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
